// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a single memory port between an instruction-fetch requester (if_*)
//   and a load/store requester (ls_*). One transaction is in flight at a time.
//   Grants are issued combinationally in IDLE; the winning request's fields are
//   latched and presented on mem_* for the whole BUSY period. A transaction ends
//   on mem_ack or, if the memory never answers, after TIMEOUT_CYCLES BUSY cycles
//   (done + err, rdata forced to 0).
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   if_req/if_addr      fetch request (read only)
//   if_gnt/if_done      fetch accepted / completed pulses
//   if_rdata            fetch data, non-zero only with if_done
//   ls_req/we/addr/wdata/mask  load/store request
//   ls_gnt/ls_done      load/store accepted / completed pulses
//   ls_rdata            load data, non-zero only with ls_done on a load
//   mem_req/we/addr/wdata/mask  registered memory transaction
//   mem_ack/mem_rdata   memory completion and read data (same cycle)
//   err                 timeout pulse, coincident with the owner's done
//   stall               core stall request
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_mask,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        stall
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;
  typedef enum logic {WIN_IF, WIN_LS} winner_e;

  state_e        state_q, state_d;
  winner_e       last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    if_done  = 1'b0;
    ls_done  = 1'b0;
    err      = 1'b0;
    if_rdata = '0;
    ls_rdata = '0;

    // Pulses are suppressed while reset is asserted: the edge that samples
    // rst=0 discards whatever this cycle would have granted or completed.
    if (rst) begin
      case (state_q)
        IDLE: begin
          // On a tie the requester that was not served last wins.
          if (ls_req && (!if_req || last_q == WIN_IF)) begin
            ls_gnt  = 1'b1;
            state_d = BUSY_LS;
            last_d  = WIN_LS;
            cnt_d   = '0;
            we_d    = ls_we;
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            mask_d  = ls_mask;
          end else if (if_req) begin
            if_gnt  = 1'b1;
            state_d = BUSY_IF;
            last_d  = WIN_IF;
            cnt_d   = '0;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            mask_d  = '1;
          end
        end
        BUSY_IF, BUSY_LS: begin
          // An ack in the final allowed cycle still counts as a normal completion.
          if (mem_ack || cnt_q == CNT_LAST) begin
            state_d = IDLE;
            err     = ~mem_ack;
            if (state_q == BUSY_LS) begin
              ls_done  = 1'b1;
              ls_rdata = (mem_ack && !we_q) ? mem_rdata : '0;
            end else begin
              if_done  = 1'b1;
              if_rdata = mem_ack ? mem_rdata : '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= WIN_IF;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_mask  = mask_q;
  assign stall     = (state_q != IDLE) | (if_req & ~if_gnt) | (ls_req & ~ls_gnt);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_mask;
  logic        ls_gnt, ls_done;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err, stall;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .stall(stall)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one pending transaction with its age in BUSY cycles.
  bit          m_busy = 0;
  bit          m_owner_ls = 0;
  bit          m_last_ls = 0;
  int          m_age = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_mask = 0;
  bit          e_gif = 0, e_gls = 0;

  always @(negedge clk) begin : model
    bit e_dif, e_dls, e_err, fin, e_stall;
    logic [31:0] e_rif, e_rls, rd;
    e_gif = 0; e_gls = 0; e_dif = 0; e_dls = 0; e_err = 0; fin = 0;
    e_rif = 0; e_rls = 0; rd = 0;
    if (rst === 1'b1) begin
      if (!m_busy) begin
        if (ls_req && (!if_req || !m_last_ls)) e_gls = 1;
        else if (if_req) e_gif = 1;
      end else begin
        fin = mem_ack || (m_age == T);
        if (fin) begin
          e_err = !mem_ack;
          rd = (mem_ack && !m_we) ? mem_rdata : 32'h0;
          if (m_owner_ls) begin e_dls = 1; e_rls = rd; end
          else begin e_dif = 1; e_rif = rd; end
        end
      end
    end
    e_stall = m_busy | (if_req & !e_gif) | (ls_req & !e_gls);
    if (chk_en) begin
      check("if_gnt", {31'b0, if_gnt}, {31'b0, e_gif});
      check("ls_gnt", {31'b0, ls_gnt}, {31'b0, e_gls});
      check("if_done", {31'b0, if_done}, {31'b0, e_dif});
      check("ls_done", {31'b0, ls_done}, {31'b0, e_dls});
      check("err", {31'b0, err}, {31'b0, e_err});
      check("if_rdata", if_rdata, e_rif);
      check("ls_rdata", ls_rdata, e_rls);
      check("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
      check("stall", {31'b0, stall}, {31'b0, e_stall});
      if (m_busy) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        check("mem_addr", mem_addr, m_addr);
        check("mem_mask", {28'b0, mem_mask}, {28'b0, m_mask});
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (rst !== 1'b1) begin
      m_busy = 0; m_last_ls = 0; m_age = 0;
    end else if (e_gls) begin
      m_busy = 1; m_owner_ls = 1; m_last_ls = 1; m_age = 1;
      m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_mask = ls_mask;
    end else if (e_gif) begin
      m_busy = 1; m_owner_ls = 0; m_last_ls = 0; m_age = 1;
      m_we = 0; m_addr = if_addr; m_wdata = 0; m_mask = 4'hF;
    end else if (fin) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_age++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    bit exp_ls;
    int ack_pct;
    rst = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_wdata = 0; ls_mask = 0; mem_ack = 0; mem_rdata = 0;
    cyc();
    chk_en = 1;
    neg();
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_mask", {28'b0, mem_mask}, 32'd0);
    cyc();
    rst = 1;

    // Single load, ack three cycles after grant.
    ls_req = 1; ls_we = 0; ls_addr = 32'h100;
    neg(); check("load_gnt", {31'b0, ls_gnt}, 32'd1);
    cyc(); ls_req = 0;
    neg(); check("load_mreq", {31'b0, mem_req}, 32'd1); check("load_maddr", mem_addr, 32'h100);
    cyc(); neg();
    cyc(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    neg(); check("load_done", {31'b0, ls_done}, 32'd1);
    check("load_rdata", ls_rdata, 32'hDEADBEEF); check("load_err", {31'b0, err}, 32'd0);
    cyc(); mem_ack = 0;
    neg(); check("load_idle", {31'b0, mem_req}, 32'd0);

    // Store fields held until ack, rdata 0 on completion.
    cyc(); ls_req = 1; ls_we = 1; ls_mask = 4'b0011; ls_wdata = 32'h0000ABCD; ls_addr = 32'h200;
    mem_rdata = 32'hFFFFFFFF;
    neg(); check("st_gnt", {31'b0, ls_gnt}, 32'd1);
    cyc(); ls_req = 0; ls_wdata = 0; ls_mask = 0; ls_we = 0;
    neg(); check("st_we", {31'b0, mem_we}, 32'd1); check("st_mask", {28'b0, mem_mask}, 32'h3);
    check("st_wdata", mem_wdata, 32'h0000ABCD);
    cyc(); mem_ack = 1;
    neg(); check("st_wdata2", mem_wdata, 32'h0000ABCD); check("st_done", {31'b0, ls_done}, 32'd1);
    check("st_rdata", ls_rdata, 32'd0);
    cyc(); mem_ack = 0;

    // Timeout after T BUSY cycles, late ack ignored.
    ls_req = 1; ls_addr = 32'h300; mem_rdata = 32'h12345678;
    neg(); check("to_gnt", {31'b0, ls_gnt}, 32'd1);
    cyc(); ls_req = 0;
    for (int c = 1; c <= T; c++) begin
      neg();
      if (c == T) begin
        check("to_done", {31'b0, ls_done}, 32'd1); check("to_err", {31'b0, err}, 32'd1);
        check("to_rdata", ls_rdata, 32'd0);
      end
      cyc();
    end
    neg(); cyc(); mem_ack = 1;
    neg(); check("late_ack_done", {31'b0, ls_done}, 32'd0); check("late_ack_err", {31'b0, err}, 32'd0);
    cyc(); mem_ack = 0;

    // Fetch waiting behind a load keeps stall high, granted in first IDLE cycle.
    ls_req = 1; ls_addr = 32'h400;
    neg(); check("stl_lsgnt", {31'b0, ls_gnt}, 32'd1);
    cyc(); ls_req = 0; if_req = 1; if_addr = 32'h500;
    neg(); check("stl_c1", {31'b0, stall}, 32'd1); check("stl_nogif", {31'b0, if_gnt}, 32'd0);
    cyc(); neg(); check("stl_c2", {31'b0, stall}, 32'd1);
    cyc(); mem_ack = 1;
    neg(); check("stl_c3", {31'b0, stall}, 32'd1);
    cyc(); mem_ack = 0;
    neg(); check("stl_ifgnt", {31'b0, if_gnt}, 32'd1); check("stl_c4", {31'b0, stall}, 32'd0);
    cyc(); if_req = 0; mem_ack = 1;
    neg(); cyc(); mem_ack = 0;

    // Reset in BUSY cycle 2: no done, mem_req drops, next tie goes to ls.
    ls_req = 1; ls_addr = 32'h600;
    neg(); check("rb_gnt", {31'b0, ls_gnt}, 32'd1);
    cyc(); ls_req = 0;
    neg(); cyc(); rst = 0; mem_ack = 1;
    neg(); check("rb_nodone", {31'b0, ls_done}, 32'd0);
    cyc(); rst = 1; mem_ack = 0; if_req = 1; if_addr = 32'h700; ls_req = 1; ls_addr = 32'h800;
    neg(); check("rb_mreq", {31'b0, mem_req}, 32'd0); check("rb_tie_ls", {31'b0, ls_gnt}, 32'd1);
    check("rb_tie_if", {31'b0, if_gnt}, 32'd0);
    cyc(); ls_req = 0; if_req = 0; mem_ack = 1;
    neg(); cyc(); mem_ack = 0;

    // Alternating ties after reset, single-cycle ack.
    do_reset();
    if_req = 1; if_addr = 32'h1000; ls_req = 1; ls_we = 0; ls_addr = 32'h2000; mem_ack = 1;
    for (int k = 0; k < 4; k++) begin
      exp_ls = (k % 2 == 0);
      neg(); check("tie_ls", {31'b0, ls_gnt}, {31'b0, exp_ls});
      check("tie_if", {31'b0, if_gnt}, {31'b0, !exp_ls});
      cyc(); neg();
      check("tie_addr", mem_addr, exp_ls ? 32'h2000 : 32'h1000);
      cyc();
    end
    if_req = 0; ls_req = 0; mem_ack = 0;

    // Randomized traffic in phases of differing memory responsiveness.
    for (int p = 0; p < 8; p++) begin
      ack_pct = (p % 4 == 1) ? 0 : (p % 4 == 2) ? 100 : int'($urandom_range(5, 70));
      for (int c = 0; c < 500; c++) begin
        neg();
        cyc();
        if (e_gif) if_req = 0;
        else if (if_req && $urandom_range(0, 99) < 5) if_req = 0;
        if (!if_req && $urandom_range(0, 99) < 40) begin
          if_req = 1; if_addr = $urandom;
        end
        if (e_gls) ls_req = 0;
        else if (ls_req && $urandom_range(0, 99) < 5) ls_req = 0;
        if (!ls_req && $urandom_range(0, 99) < 40) begin
          ls_req = 1; ls_we = $urandom_range(0, 1); ls_addr = $urandom;
          ls_wdata = $urandom; ls_mask = 4'($urandom_range(0, 15));
        end
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        mem_rdata = $urandom;
        rst = ($urandom_range(0, 299) != 0);
      end
    end
    rst = 1;
    neg();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
